// File: rtl/fxp_pkg.sv
// fxp_pkg: shared definitions for the fixed-point stream accumulator.
//   - FSM state encodings (IDLE, ACC, NORM, DONE)
//   - default QI/QF field width
//   - most-positive / most-negative value helpers for a given word width
package fxp_pkg;

    localparam int QW_DEF = 5;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACC  = 2'd1;
    localparam logic [1:0] ST_NORM = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Q-format descriptor carried alongside a value.
    typedef struct packed {
        logic [QW_DEF-1:0] qi;
        logic [QW_DEF-1:0] qf;
    } fxp_fmt_t;

    // Largest positive two's-complement value of a w-bit word, zero-extended to 64 bits.
    function automatic logic [63:0] fxp_most_pos(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    // Most negative two's-complement value of a w-bit word, in the low w bits.
    function automatic logic [63:0] fxp_most_neg(input int w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/fxp_accum_stream_if.sv
// fxp_accum_stream_if: addend input stream, per-packet start format and
// result output stream for fxp_accum_stream.
//   in_valid/in_ready/in_data/in_last : addend stream
//   cfg_qi/cfg_qf                     : starting Q-format, taken on first beat
//   out_valid/out_ready               : result handshake
//   out_data/out_qi/out_qf/out_sat    : result value, format and saturation flag
// modport slave  : accumulator side
// modport master : producer/consumer side (multiplier array + result writer)
interface fxp_accum_stream_if #(
    parameter int WIDTH = 16,
    parameter int QW    = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic [QW-1:0]    cfg_qi;
    logic [QW-1:0]    cfg_qf;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [QW-1:0]    out_qi;
    logic [QW-1:0]    out_qf;
    logic             out_sat;

    modport slave (
        input  in_valid, in_data, in_last, cfg_qi, cfg_qf, out_ready,
        output in_ready, out_valid, out_data, out_qi, out_qf, out_sat
    );

    modport master (
        output in_valid, in_data, in_last, cfg_qi, cfg_qf, out_ready,
        input  in_ready, out_valid, out_data, out_qi, out_qf, out_sat
    );
endinterface

// File: rtl/fxp_add_ovf.sv
// fxp_add_ovf: combinational aligned adder for the accumulator.
//   acc_i    : current accumulator (signed, WIDTH)
//   addend_i : incoming addend in the packet's starting format
//   shift_i  : number of integer-bit growths so far; addend is aligned by >>> shift_i
//   sum_o    : low WIDTH bits of the WIDTH+1-bit sum
//   half_o   : sum[WIDTH:1], the sum re-expressed with one more integer bit
//   ovf_o    : sum does not fit in WIDTH bits
//   neg_o    : sign of the true (WIDTH+1-bit) sum, picks the saturation rail
module fxp_add_ovf #(
    parameter int WIDTH = 16,
    parameter int QW    = 5
) (
    input  logic [WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0] addend_i,
    input  logic [QW-1:0]    shift_i,
    output logic [WIDTH-1:0] sum_o,
    output logic [WIDTH-1:0] half_o,
    output logic             ovf_o,
    output logic             neg_o
);
    logic [WIDTH-1:0] aligned;
    logic [WIDTH:0]   sum;

    always_comb begin
        // Shifting by the full width or more leaves only sign bits.
        if (32'(shift_i) >= WIDTH) begin
            aligned = {WIDTH{addend_i[WIDTH-1]}};
        end else begin
            aligned = $unsigned($signed(addend_i) >>> shift_i);
        end
    end

    assign sum    = {acc_i[WIDTH-1], acc_i} + {aligned[WIDTH-1], aligned};
    assign sum_o  = sum[WIDTH-1:0];
    assign half_o = sum[WIDTH:1];
    assign ovf_o  = sum[WIDTH] ^ sum[WIDTH-1];
    assign neg_o  = sum[WIDTH];

endmodule

// File: rtl/fxp_accum_stream.sv
// fxp_accum_stream: streaming signed fixed-point accumulator with dynamic
// Q-format. Sums one packet of addends; on overflow the integer field grows
// by one bit (fraction shrinks) instead of wrapping, and saturates only once
// no fraction bits remain. Reports value + QI/QF + sticky saturation flag.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   s     : fxp_accum_stream_if.slave (addend stream, cfg, result stream)
// Build option: FXP_RENORM_EN adds a NORM state after the last beat that
// shifts out redundant sign bits into the fraction field while qi > 1.
module fxp_accum_stream
    import fxp_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int QW    = QW_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fxp_accum_stream_if.slave    s
);
    localparam logic [63:0]      MOST_POS64 = fxp_most_pos(WIDTH);
    localparam logic [63:0]      MOST_NEG64 = fxp_most_neg(WIDTH);
    localparam logic [WIDTH-1:0] MOST_POS   = MOST_POS64[WIDTH-1:0];
    localparam logic [WIDTH-1:0] MOST_NEG   = MOST_NEG64[WIDTH-1:0];

`ifdef FXP_RENORM_EN
    localparam logic [1:0] ST_AFTER_LAST = ST_NORM;
`else
    localparam logic [1:0] ST_AFTER_LAST = ST_DONE;
`endif

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [QW-1:0]    qi_q, qi_d;
    logic [QW-1:0]    qf_q, qf_d;
    logic [QW-1:0]    shift_q, shift_d;
    logic             sat_q, sat_d;

    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic [QW-1:0]    out_qi_q;
    logic [QW-1:0]    out_qf_q;
    logic             out_sat_q;

    logic             in_ready_w;
    logic             beat;
    logic [WIDTH-1:0] add_sum;
    logic [WIDTH-1:0] add_half;
    logic             add_ovf;
    logic             add_neg;

    // Gated by rst_n so the input side is closed while reset is held.
    assign in_ready_w = rst_n & ((state_q == ST_IDLE) | (state_q == ST_ACC));
    assign beat       = s.in_valid & in_ready_w;

    fxp_add_ovf #(
        .WIDTH (WIDTH),
        .QW    (QW)
    ) u_add (
        .acc_i    (acc_q),
        .addend_i (s.in_data),
        .shift_i  (shift_q),
        .sum_o    (add_sum),
        .half_o   (add_half),
        .ovf_o    (add_ovf),
        .neg_o    (add_neg)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        qi_d    = qi_q;
        qf_d    = qf_q;
        shift_d = shift_q;
        sat_d   = sat_q;

        case (state_q)
            ST_IDLE: begin
                if (beat) begin
                    acc_d   = s.in_data;
                    qi_d    = s.cfg_qi;
                    qf_d    = s.cfg_qf;
                    shift_d = '0;
                    sat_d   = 1'b0;
                    state_d = s.in_last ? ST_AFTER_LAST : ST_ACC;
                end
            end

            ST_ACC: begin
                if (beat) begin
                    if (!add_ovf) begin
                        acc_d = add_sum;
                    end else if (qf_q != '0) begin
                        // Trade one fraction bit for one integer bit; later
                        // addends must be shifted one more place to line up.
                        acc_d   = add_half;
                        qi_d    = qi_q + QW'(1);
                        qf_d    = qf_q - QW'(1);
                        shift_d = shift_q + QW'(1);
                    end else begin
                        acc_d = add_neg ? MOST_NEG : MOST_POS;
                        sat_d = 1'b1;
                    end
                    if (s.in_last) begin
                        state_d = ST_AFTER_LAST;
                    end
                end
            end

`ifdef FXP_RENORM_EN
            ST_NORM: begin
                // A redundant sign bit can move into the fraction field.
                if ((acc_q[WIDTH-1] == acc_q[WIDTH-2]) && (qi_q > QW'(1))) begin
                    acc_d = {acc_q[WIDTH-2:0], 1'b0};
                    qi_d  = qi_q - QW'(1);
                    qf_d  = qf_q + QW'(1);
                end else begin
                    state_d = ST_DONE;
                end
            end
`endif

            ST_DONE: begin
                if (s.out_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            qi_q    <= '0;
            qf_q    <= '0;
            shift_q <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            qi_q    <= qi_d;
            qf_q    <= qf_d;
            shift_q <= shift_d;
            sat_q   <= sat_d;
        end
    end

    // Result registers are captured on the edge that enters DONE and then
    // hold steady for as long as the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_qi_q    <= '0;
            out_qf_q    <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            out_valid_q <= (state_d == ST_DONE);
            if ((state_d == ST_DONE) && (state_q != ST_DONE)) begin
                out_data_q <= acc_d;
                out_qi_q   <= qi_d;
                out_qf_q   <= qf_d;
                out_sat_q  <= sat_d;
            end
        end
    end

    assign s.in_ready  = in_ready_w;
    assign s.out_valid = out_valid_q;
    assign s.out_data  = out_data_q;
    assign s.out_qi    = out_qi_q;
    assign s.out_qf    = out_qf_q;
    assign s.out_sat   = out_sat_q;

endmodule

// File: tb/tb_fxp_accum_stream.sv
module tb_fxp_accum_stream;
    localparam int WIDTH = 16;
    localparam int QW    = 5;

`ifdef FXP_RENORM_EN
    localparam bit RENORM = 1'b1;
`else
    localparam bit RENORM = 1'b0;
`endif

    logic clk;
    logic rst_n;

    int n_checks = 0;
    int n_errors = 0;

    fxp_accum_stream_if #(.WIDTH(WIDTH), .QW(QW)) bus ();

    fxp_accum_stream #(.WIDTH(WIDTH), .QW(QW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .s     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Sends n beats (d0..d2), waits for the result, checks it, optionally
    // stalls the consumer for hold cycles, then completes the handshake.
    task automatic run_packet(input string tag,
                              input logic [QW-1:0] qi, input logic [QW-1:0] qf,
                              input int n,
                              input logic [WIDTH-1:0] d0, input logic [WIDTH-1:0] d1,
                              input logic [WIDTH-1:0] d2,
                              input logic [WIDTH-1:0] e_data,
                              input logic [QW-1:0] e_qi, input logic [QW-1:0] e_qf,
                              input logic e_sat, input int e_lat, input int hold);
        logic [WIDTH-1:0] d [3];
        int lat;
        int guard;
        d[0] = d0; d[1] = d1; d[2] = d2;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_data  = d[i];
            bus.in_last  = (i == n - 1);
            bus.cfg_qi   = qi;
            bus.cfg_qf   = qf;
            guard = 0;
            while (!bus.in_ready && guard < 20) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 20) check({tag, " in_ready timeout"}, 32'(bus.in_ready), 32'd1);
            @(posedge clk);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!bus.out_valid) begin
            check({tag, " out_valid timeout"}, 32'(bus.out_valid), 32'd1);
        end else begin
            if (e_lat > 0) check({tag, " latency"}, 32'(lat), 32'(e_lat));
            check({tag, " data"}, 32'(bus.out_data), 32'(e_data));
            check({tag, " qi"},   32'(bus.out_qi),   32'(e_qi));
            check({tag, " qf"},   32'(bus.out_qf),   32'(e_qf));
            check({tag, " sat"},  32'(bus.out_sat),  32'(e_sat));
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                check({tag, " hold valid"},    32'(bus.out_valid), 32'd1);
                check({tag, " hold data"},     32'(bus.out_data),  32'(e_data));
                check({tag, " hold qi"},       32'(bus.out_qi),    32'(e_qi));
                check({tag, " hold in_ready"}, 32'(bus.in_ready),  32'd0);
            end
            bus.out_ready = 1'b1;
            @(negedge clk);
            bus.out_ready = 1'b0;
            check({tag, " valid after hs"},    32'(bus.out_valid), 32'd0);
            check({tag, " in_ready after hs"}, 32'(bus.in_ready),  32'd1);
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.cfg_qi    = '0;
        bus.cfg_qf    = '0;
        bus.out_ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst in_ready",  32'(bus.in_ready),  32'd0);
        check("rst out_valid", 32'(bus.out_valid), 32'd0);
        check("rst out_data",  32'(bus.out_data),  32'd0);
        check("rst out_qi",    32'(bus.out_qi),    32'd0);
        check("rst out_sat",   32'(bus.out_sat),   32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post-rst in_ready", 32'(bus.in_ready), 32'd1);

        // 0x4000+0x4000 overflows once: halved to 0x4000 in Q9.7.
        run_packet("grow", 5'd8, 5'd8, 2, 16'h4000, 16'h4000, 16'h0000,
                   16'h4000, 5'd9, 5'd7, 1'b0, RENORM ? 2 : 1, 0);
        // Third addend aligned by one place: 0x0100 -> 0x0080.
        run_packet("align", 5'd8, 5'd8, 3, 16'h4000, 16'h4000, 16'h0100,
                   16'h4080, 5'd9, 5'd7, 1'b0, 0, 0);
        // Negative overflow: -32768 + -1 -> halved 0xBFFF.
        run_packet("neg ovf", 5'd8, 5'd8, 2, 16'h8000, 16'hFFFF, 16'h0000,
                   16'hBFFF, 5'd9, 5'd7, 1'b0, 0, 0);
        // -16384 + -16384 = -32768 fits exactly.
        run_packet("neg edge", 5'd8, 5'd8, 2, 16'hC000, 16'hC000, 16'h0000,
                   16'h8000, 5'd8, 5'd8, 1'b0, 0, 0);
        // No fraction left: saturate to most-positive.
        run_packet("sat", 5'd16, 5'd0, 2, 16'h7FFF, 16'h0001, 16'h0000,
                   16'h7FFF, 5'd16, 5'd0, 1'b1, 0, 0);
        // Sticky flag cleared for the next packet.
        run_packet("sat clr", 5'd16, 5'd0, 1, 16'h0001, 16'h0000, 16'h0000,
                   RENORM ? 16'h4000 : 16'h0001, RENORM ? 5'd2 : 5'd16,
                   RENORM ? 5'd14 : 5'd0, 1'b0, 0, 0);
        // Small sum: renormalises 7 places when the feature is built in.
        run_packet("renorm", 5'd8, 5'd8, 2, 16'h0010, 16'h0010, 16'h0000,
                   RENORM ? 16'h1000 : 16'h0020, RENORM ? 5'd1 : 5'd8,
                   RENORM ? 5'd15 : 5'd8, 1'b0, RENORM ? 9 : 1, 0);
        // Consumer stall for 5 cycles.
        run_packet("stall", 5'd8, 5'd8, 2, 16'h4000, 16'h4000, 16'h0000,
                   16'h4000, 5'd9, 5'd7, 1'b0, 0, 5);

        // Reset in the middle of a packet discards it.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h1234;
        bus.in_last  = 1'b0;
        bus.cfg_qi   = 5'd8;
        bus.cfg_qf   = 5'd8;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst in_ready", 32'(bus.in_ready), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("midrst out_valid", 32'(bus.out_valid), 32'd0);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("after rst out_valid", 32'(bus.out_valid), 32'd0);
        end
        run_packet("after rst", 5'd8, 5'd8, 2, 16'h8000, 16'hFFFF, 16'h0000,
                   16'hBFFF, 5'd9, 5'd7, 1'b0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
